// File: rtl/pisp_mem_pkg.sv
// pisp_mem_pkg: shared state encodings, data width and word-align mask for the PISP memory stage.
package pisp_mem_pkg;
  localparam int DW = 32;
  localparam logic [DW-1:0] ALIGN_MASK = {{(DW-2){1'b1}}, 2'b00};
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: counts REQ cycles and flags expiry on the LIMIT-th cycle.
module mem_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  logic [W-1:0] cnt;
  assign expire = en && (cnt == LAST);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: req/ack memory stage owning IR and MDR; MEM_TIMEOUT_EN adds a bus_error timeout.
module mem_access_unit
  import pisp_mem_pkg::*;
#(
  parameter int DW = pisp_mem_pkg::DW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic          IorD,
  input  logic          IRWrite,
  input  logic [DW-1:0] pc,
  input  logic [DW-1:0] alu_out,
  input  logic [DW-1:0] wdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] ir,
  output logic [DW-1:0] mdr,
  output logic          stall,
  output logic          bus_error
);
  state_t state;
  logic irw_q;
  logic start;
  logic expire;
  logic [DW-1:0] sel;
  assign sel = IorD ? alu_out : pc;
  assign start = (state == IDLE) && (MemRead || MemWrite);
  assign mem_req = state == REQ;
  assign stall = start || mem_req;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      irw_q <= 1'b0;
      ir <= '0;
      mdr <= '0;
    end else if (start) begin
      state <= REQ;
      mem_addr <= {sel[DW-1:2], 2'b00};
      mem_we <= MemWrite;
      mem_wdata <= wdata;
      irw_q <= IRWrite;
    end else if (mem_req && mem_ack) begin
      state <= DONE;
      if (!mem_we) begin
        mdr <= mem_rdata;
        if (irw_q) ir <= mem_rdata;
      end
    end else if (mem_req && expire) begin
      state <= DONE;
    end else if (state == DONE) begin
      state <= IDLE;
    end
`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .en    (mem_req),
    .expire(expire)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) bus_error <= 1'b0;
    else if (mem_req && !mem_ack && expire) bus_error <= 1'b1;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire = 1'b0;
  assign bus_error = 1'b0;
`endif
endmodule
